// File: rtl/serial_link_pkg.sv
// serial_link_pkg: word width, FSM encoding and counter-width helper shared by both ends of the serial link
package serial_link_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready-loaded word shifted out LSB first with bit-valid, frame-start and last-bit flags
module piso_serializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_inv,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             wyjscie,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             last_bit,
    output logic             busy
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dout_q, dout_d, vld_q, vld_d, fs_q, fs_d, lb_q, lb_d;
    logic             at_last, accept;
    logic [WIDTH-1:0] word;
    assign at_last    = (state_q == SHIFT) && (cnt_q == LAST);
    assign load_ready = reset_n & ((state_q == IDLE) | at_last);
    assign accept     = load_valid & load_ready;
    assign word       = load_inv ? ~load_data : load_data;
    // a load on the last bit takes priority, giving zero-gap back-to-back frames
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = 1'b0;
        vld_d   = 1'b0;
        fs_d    = 1'b0;
        lb_d    = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = word;
            cnt_d   = '0;
            dout_d  = word[0];
            vld_d   = 1'b1;
            fs_d    = 1'b1;
            lb_d    = (WIDTH == 1);
        end else if (state_q == SHIFT && !at_last) begin
            shreg_d = shreg_q >> 1;
            dout_d  = shreg_q[1];
            cnt_d   = cnt_q + 1'b1;
            vld_d   = 1'b1;
            lb_d    = (cnt_d == LAST);
        end else if (at_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            lb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            lb_q    <= lb_d;
        end
    end
    assign wyjscie     = dout_q;
    assign bit_valid   = vld_q;
    assign frame_start = fs_q;
    assign last_bit    = lb_q;
    assign busy        = (state_q == SHIFT);
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed and loopback checks of the LSB-first serializer
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_inv = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready, wyjscie, bit_valid, frame_start, last_bit, busy;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_word;
    int         rx_idx = 0;
    logic [7:0] rx_q[$];

    piso_serializer #(.WIDTH(8)) dut (
        .clock(clk), .reset_n(reset_n), .load_data(load_data), .load_inv(load_inv),
        .load_valid(load_valid), .load_ready(load_ready), .wyjscie(wyjscie),
        .bit_valid(bit_valid), .frame_start(frame_start), .last_bit(last_bit), .busy(busy)
    );

    always #5 clk = ~clk;

    // independent receiver: realigns on frame_start, collects a word on last_bit
    always @(negedge clk) begin
        if (reset_n && bit_valid) begin
            if (frame_start) rx_idx = 0;
            rx_word[rx_idx[2:0]] = wyjscie;
            rx_idx++;
            if (last_bit) rx_q.push_back(rx_word);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required end before 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        load_valid = 1'b1;
        load_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({load_ready, wyjscie, bit_valid, frame_start, last_bit, busy} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b want 000000", i,
                         {load_ready, wyjscie, bit_valid, frame_start, last_bit, busy});
            end
        end
        reset_n    = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_ready, bit_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got ready/valid/busy %b want 100", {load_ready, bit_valid, busy});
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic inv, input logic [7:0] exp);
        load_data  = d;
        load_inv   = inv;
        load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        load_inv   = ~inv;
        load_data  = ~d;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({wyjscie, bit_valid, frame_start, last_bit, busy, load_ready} !==
                {exp[k], 1'b1, k == 0, k == 7, 1'b1, k == 7}) begin
                errors++;
                $display("FAIL frame_%h bit %0d: got dout/vld/fs/lb/busy/rdy %b want %b", d, k,
                         {wyjscie, bit_valid, frame_start, last_bit, busy, load_ready},
                         {exp[k], 1'b1, k == 0, k == 7, 1'b1, k == 7});
            end
            @(negedge clk);
        end
        checks++;
        if ({wyjscie, bit_valid, last_bit, busy, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL frame_%h idle: got dout/vld/lb/busy/rdy %b want 00001", d,
                     {wyjscie, bit_valid, last_bit, busy, load_ready});
        end
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b0, 8'hA5);
    endtask

    task automatic test_invert();
        send_frame(8'h0F, 1'b1, 8'hF0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        exp        = 16'h8001;
        load_data  = 8'h01;
        load_inv   = 1'b0;
        load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) load_data = 8'h80;
            if (i == 8) load_valid = 1'b0;
            checks++;
            if ({wyjscie, bit_valid, frame_start} !== {exp[i], 1'b1, (i == 0) || (i == 8)}) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got dout/vld/fs %b want %b", i + 1,
                         {wyjscie, bit_valid, frame_start}, {exp[i], 1'b1, (i == 0) || (i == 8)});
            end
            @(negedge clk);
        end
        checks++;
        if ({bit_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_back end: got vld/busy %b want 00", {bit_valid, busy});
        end
    endtask

    task automatic test_mid_reset();
        load_data  = 8'hFF;
        load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({wyjscie, bit_valid} !== 2'b11) begin
                errors++;
                $display("FAIL mid_reset bit %0d: got dout/vld %b want 11", i, {wyjscie, bit_valid});
            end
            if (i < 3) @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({wyjscie, bit_valid, busy, load_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset abandon: got dout/vld/busy/rdy %b want 0000",
                     {wyjscie, bit_valid, busy, load_ready});
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset ready: got %b want 1", load_ready);
        end
        send_frame(8'h3C, 1'b0, 8'h3C);
    endtask

    task automatic test_loopback();
        logic [7:0] exp_q[$];
        logic [7:0] d, got;
        logic       inv;
        int         n;
        rx_q.delete();
        for (int w = 0; w < 100; w++) begin
            d          = 8'($urandom);
            inv        = 1'($urandom);
            load_data  = d;
            load_inv   = inv;
            load_valid = 1'b1;
            n          = 0;
            while (!load_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                checks++;
                errors++;
                $display("FAIL loopback_ready word %0d: got no load_ready within 20 cycles, required ready", w);
            end
            exp_q.push_back(inv ? ~d : d);
            @(negedge clk);
        end
        load_valid = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (rx_q.size() != 100) begin
            errors++;
            $display("FAIL loopback_count: got %0d words want 100", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            d   = exp_q.pop_front();
            got = rx_q.pop_front();
            checks++;
            if (got !== d) begin
                errors++;
                $display("FAIL loopback_word: got %h want %h", got, d);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        test_reset();
        test_single();
        test_invert();
        test_back_to_back();
        test_mid_reset();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the sending end of the team's 8-bit serial-in shift-register link.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clock.
- Each bit carries a bit-valid qualifier, and the first bit of every frame is flagged so the receiver can realign its bit index to 0.
- An optional complement-on-load input mirrors the receiver's non-functional (invert) mode.

Parameters:
- WIDTH, 8, word length in bits; legal values 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- load_data  input  WIDTH  parallel word to transmit.
- load_inv  input  1  when 1 at acceptance, the word is complemented before shifting.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  serializer can accept a word this cycle.
- wyjscie  output  1  serial data bit, registered.
- bit_valid  output  1  wyjscie carries a frame bit this cycle, registered.
- frame_start  output  1  high with bit 0 of each frame, registered.
- last_bit  output  1  high with bit WIDTH-1 of each frame, registered.
- busy  output  1  a frame is in progress (state SHIFT).

Behaviour:
- Reset, while reset_n = 0 at a clock edge:
  - state goes to IDLE and the counter and shift register clear.
  - wyjscie, bit_valid, frame_start and last_bit go to 0; busy = 0.
  - load_ready is forced to 0 while reset_n is low, and no load is accepted.
- Reset mid-frame:
  - the frame is abandoned and no further bits are emitted.
  - the first cycle after release is IDLE, with load_ready = 1.
- States:
  - IDLE to SHIFT on acceptance.
  - SHIFT to SHIFT on the last bit if a new word is accepted in that cycle.
  - SHIFT to IDLE on the last bit with no new acceptance.
- Acceptance: load_valid & load_ready at a rising edge.
- load_ready (combinational) = reset_n & (state == IDLE | (state == SHIFT & cnt == WIDTH-1)). This gives back-to-back frames with zero gap.
- Latency:
  - for a word accepted at edge N, bit 0 appears on wyjscie during cycle N+1.
  - bit k appears during cycle N+1+k.
  - bit WIDTH-1 appears during cycle N+WIDTH.
- Load at acceptance:
  - shreg <= load_inv ? ~load_data : load_data.
  - wyjscie <= bit 0 of that value.
  - bit_valid <= 1, frame_start <= 1, cnt <= 0.
  - last_bit <= 1 only if WIDTH == 1 (not legal, so always 0 in practice).
- Each following SHIFT cycle with cnt < WIDTH-1:
  - shreg shifts right by one and wyjscie <= the next bit; cnt <= cnt+1.
  - frame_start <= 0.
  - last_bit <= 1 when the new cnt = WIDTH-1.
- On the cycle after last_bit with no new acceptance: bit_valid, wyjscie and last_bit go to 0, and state is IDLE.
- Simultaneous last bit and new acceptance: the next cycle carries bit 0 of the new word with frame_start = 1 and bit_valid held at 1.
- load_valid while not ready: ignored. load_data must be held by the producer; the serializer never captures it.
- wyjscie idles at 0 whenever bit_valid = 0.
- load_inv is sampled only at acceptance. Changes during a frame have no effect.

Decomposition:
- Shared package (serial_link_pkg): WIDTH default (8), state encoding (IDLE = 1'b0, SHIFT = 1'b1) and CNT_W helper. The same package is shared with the receiver.
- No sub-module is required. The shift register, counter and FSM form one flat module of roughly 150 lines.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with load_valid = 1 -> no acceptance; all outputs 0; load_ready = 1 on the first cycle after release.
- Single frame: load 8'hA5, load_inv = 0 at edge N -> wyjscie = 1,0,1,0,0,1,0,1 over cycles N+1..N+8; frame_start only at N+1; last_bit only at N+8; IDLE at N+9.
- Invert: load 8'h0F with load_inv = 1 -> wyjscie = 0,0,0,0,1,1,1,1 (transmits 8'hF0).
- Back-to-back: 8'h01 then 8'h80, with load_valid held -> 16 consecutive bit_valid cycles; bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; frame_start at cycles 1 and 9.
- Mid-frame reset: reset_n low at bit 3 of 8'hFF -> the next cycle has bit_valid = 0 and wyjscie = 0; a following load of 8'h3C serializes correctly from bit 0.
- Loopback: drive the existing receiver from wyjscie gated by bit_valid, across 100 random words with random load_inv -> the receiver word equals the transmitted (possibly complemented) value.
